// File: rtl/temp_scan_pkg.sv
// temp_scan_pkg: shared types and constants for the thermistor scan scheduler.
//   state_t    - scheduler FSM states
//   ADC_W      - raw ADC code width
//   TEMP_W     - signed temperature width (degrees C)
//   TEMP_FAULT - temperature reported for a channel whose handshake timed out
package temp_scan_pkg;

  localparam int unsigned ADC_W      = 12;
  localparam int unsigned TEMP_W     = 12;
  localparam int          TEMP_FAULT = 300;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC_REQ,
    ADC_WAIT,
    CONV_START,
    CONV_WAIT,
    STORE
  } state_t;

endpackage

// File: rtl/temp_scan_tick.sv
// temp_scan_tick: SCAN_DIV prescaler that paces channel slot starts.
// Ports:
//   clk, reset (sync, active-high)
//   en     - counter runs while high; cleared and held at 0 while low
//   tick_c - high while the counter sits at SCAN_DIV-1
module temp_scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_top;

  assign at_top = (cnt == CNT_W'(SCAN_DIV - 1));
  assign tick_c = en && at_top;

  // Free-running 0..SCAN_DIV-1 counter with clear on disable
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (at_top) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/temp_scan_sched.sv
// temp_scan_sched: round-robin thermistor scan scheduler. Time-shares one SPI
// ADC and one code-to-temperature converter among N_CH channels: per slot it
// takes 2^AVG_LOG2 samples, averages them, converts once and latches the
// signed result plus an over-temperature flag for that channel.
// Optional build macro TEMP_SCAN_TIMEOUT_EN: bounds every ADC / converter wait
// by TIMEOUT cycles, reports TEMP_FAULT with overtemp set on expiry, and adds
// the sticky per-channel fault output.
// Ports:
//   clk, reset (sync, active-high), scan_en
//   adc_req/adc_ch   -> ADC request (held until adc_ack), channel select
//   adc_ack/adc_data <- one-cycle ack with raw 12-bit code
//   conv_start/conv_code -> one-cycle start, averaged code held until done
//   conv_done/conv_temp  <- one-cycle done with signed temperature
//   temp_out   - packed results, channel c at [12c+11:12c]
//   temp_valid - channel has a result since reset
//   overtemp   - latest result of channel >= TEMP_MAX
//   fault      - (optional) sticky handshake timeout per channel
//   busy       - a slot is in progress
module temp_scan_sched
  import temp_scan_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SCAN_DIV = 50000,
`ifdef TEMP_SCAN_TIMEOUT_EN
  parameter int unsigned TIMEOUT  = 1024,
`endif
  parameter int          TEMP_MAX = 280
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   scan_en,
  output logic                                   adc_req,
  output logic [$clog2((N_CH > 1) ? N_CH : 2)-1:0] adc_ch,
  input  logic                                   adc_ack,
  input  logic [ADC_W-1:0]                       adc_data,
  output logic                                   conv_start,
  output logic [ADC_W-1:0]                       conv_code,
  input  logic                                   conv_done,
  input  logic signed [TEMP_W-1:0]               conv_temp,
  output logic [TEMP_W*N_CH-1:0]                 temp_out,
  output logic [N_CH-1:0]                        temp_valid,
  output logic [N_CH-1:0]                        overtemp,
`ifdef TEMP_SCAN_TIMEOUT_EN
  output logic [N_CH-1:0]                        fault,
`endif
  output logic                                   busy
);

  localparam int unsigned CH_W  = $clog2((N_CH > 1) ? N_CH : 2);
  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;
  localparam logic signed [TEMP_W-1:0] TEMP_MAX_S = TEMP_W'(TEMP_MAX);

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          ch, ch_nxt, ch_adv, adc_ch_nxt;
  logic [ACC_W-1:0]         acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt, cnt_inc;
  logic signed [TEMP_W-1:0] temp_lat, temp_lat_nxt;
  logic                     adc_req_nxt, conv_start_nxt, busy_nxt;
  logic [ADC_W-1:0]         conv_code_nxt;
  logic [TEMP_W*N_CH-1:0]   temp_out_nxt;
  logic [N_CH-1:0]          temp_valid_nxt, overtemp_nxt;
  logic                     tick_c;

`ifdef TEMP_SCAN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [N_CH-1:0] fault_nxt;
  logic            to_hit;
  logic            abandon;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`endif

  // Slot pacing
  temp_scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (scan_en),
    .tick_c (tick_c)
  );

  assign ch_adv  = (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    ch_nxt         = ch;
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    temp_lat_nxt   = temp_lat;
    adc_req_nxt    = adc_req;
    adc_ch_nxt     = adc_ch;
    conv_start_nxt = 1'b0;
    conv_code_nxt  = conv_code;
    temp_out_nxt   = temp_out;
    temp_valid_nxt = temp_valid;
    overtemp_nxt   = overtemp;
`ifdef TEMP_SCAN_TIMEOUT_EN
    fault_nxt      = fault;
    to_cnt_nxt     = '0;
    abandon        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (scan_en) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!scan_en)    state_nxt = IDLE;
        else if (tick_c) state_nxt = ADC_REQ;
      end
      ADC_REQ: begin
        adc_req_nxt = 1'b1;
        adc_ch_nxt  = ch;
        state_nxt   = ADC_WAIT;
      end
      ADC_WAIT: begin
        if (adc_ack) begin
          adc_req_nxt = 1'b0;
          acc_nxt     = acc + ACC_W'(adc_data);
          cnt_nxt     = cnt_inc;
          state_nxt   = (cnt_inc == CNT_W'(NSAMP)) ? CONV_START : ADC_REQ;
        end
`ifdef TEMP_SCAN_TIMEOUT_EN
        else if (to_hit) begin
          abandon = 1'b1;
        end
`endif
      end
      CONV_START: begin
        conv_code_nxt  = ADC_W'(acc >> AVG_LOG2);
        conv_start_nxt = 1'b1;
        state_nxt      = CONV_WAIT;
      end
      CONV_WAIT: begin
        if (conv_done) begin
          temp_lat_nxt = conv_temp;
          state_nxt    = STORE;
        end
`ifdef TEMP_SCAN_TIMEOUT_EN
        else if (to_hit) begin
          abandon = 1'b1;
        end
`endif
      end
      STORE: begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (ch == CH_W'(i)) begin
            temp_out_nxt[i*TEMP_W +: TEMP_W] = temp_lat;
            temp_valid_nxt[i]                = 1'b1;
            overtemp_nxt[i]                  = (temp_lat >= TEMP_MAX_S);
          end
        end
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ch_nxt    = ch_adv;
        state_nxt = WAIT_TICK;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef TEMP_SCAN_TIMEOUT_EN
    // Timed-out slot: report a hot fault value so the heater is forced off
    if (abandon) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ch == CH_W'(i)) begin
          temp_out_nxt[i*TEMP_W +: TEMP_W] = TEMP_W'(TEMP_FAULT);
          temp_valid_nxt[i]                = 1'b0;
          overtemp_nxt[i]                  = 1'b1;
          fault_nxt[i]                     = 1'b1;
        end
      end
      adc_req_nxt = 1'b0;
      acc_nxt     = '0;
      cnt_nxt     = '0;
      ch_nxt      = ch_adv;
      state_nxt   = WAIT_TICK;
    end

    // Wait-cycle counter restarts whenever a wait state is (re)entered
    if ((state == ADC_WAIT || state == CONV_WAIT) && state_nxt == state) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end
`endif

    busy_nxt = (state_nxt != IDLE) && (state_nxt != WAIT_TICK);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      acc        <= '0;
      cnt        <= '0;
      temp_lat   <= '0;
      adc_req    <= 1'b0;
      adc_ch     <= '0;
      conv_start <= 1'b0;
      conv_code  <= '0;
      temp_out   <= '0;
      temp_valid <= '0;
      overtemp   <= '0;
      busy       <= 1'b0;
`ifdef TEMP_SCAN_TIMEOUT_EN
      fault      <= '0;
      to_cnt     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      temp_lat   <= temp_lat_nxt;
      adc_req    <= adc_req_nxt;
      adc_ch     <= adc_ch_nxt;
      conv_start <= conv_start_nxt;
      conv_code  <= conv_code_nxt;
      temp_out   <= temp_out_nxt;
      temp_valid <= temp_valid_nxt;
      overtemp   <= overtemp_nxt;
      busy       <= busy_nxt;
`ifdef TEMP_SCAN_TIMEOUT_EN
      fault      <= fault_nxt;
      to_cnt     <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_temp_scan_sched.sv
// tb_temp_scan_sched: randomized scoreboard bench for temp_scan_sched.
// ADC and converter responders push expected conversions / stores into
// queues; monitors pop and compare when the DUT presents conv_start or
// finishes a slot. A per-channel model holds the expected result registers.
module tb_temp_scan_sched;

  localparam int N_CH     = 2;
  localparam int AVG_LOG2 = 2;
  localparam int SCAN_DIV = 16;
  localparam int TEMP_MAX = 280;
  localparam int NSAMP    = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        reset, scan_en;
  logic        adc_req, adc_ack;
  logic [0:0]  adc_ch;
  logic [11:0] adc_data, conv_code, conv_temp;
  logic        conv_start, conv_done, busy;
  logic [23:0] temp_out;
  logic [1:0]  temp_valid, overtemp;
`ifdef TEMP_SCAN_TIMEOUT_EN
  logic [1:0]  fault;
`endif

  temp_scan_sched #(
    .N_CH     (N_CH),
    .AVG_LOG2 (AVG_LOG2),
    .SCAN_DIV (SCAN_DIV),
`ifdef TEMP_SCAN_TIMEOUT_EN
    .TIMEOUT  (64),
`endif
    .TEMP_MAX (TEMP_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .adc_req    (adc_req),
    .adc_ch     (adc_ch),
    .adc_ack    (adc_ack),
    .adc_data   (adc_data),
    .conv_start (conv_start),
    .conv_code  (conv_code),
    .conv_done  (conv_done),
    .conv_temp  (conv_temp),
    .temp_out   (temp_out),
    .temp_valid (temp_valid),
    .overtemp   (overtemp),
`ifdef TEMP_SCAN_TIMEOUT_EN
    .fault      (fault),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int code; } conv_exp_t;
  typedef struct { int ch; int temp; bit flt; } store_exp_t;

  conv_exp_t  conv_q[$];
  store_exp_t store_q[$];
  int         forced_adc[$];
  int         forced_temp[$];

  int model_temp[N_CH];
  bit model_valid[N_CH];
  bit model_ot[N_CH];
  bit model_fault[N_CH];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_store = 0;
  int exp_ch = 0, sample_sum = 0, sample_n = 0, last_start = -1;
  bit adc_mute = 0, conv_hold = 0, conv_seen = 0, rst_flag = 0, send_stray = 0;
  bit prev_busy = 0, prev_cs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_stores(input int target, input int limit, input string name);
    int k;
    k = 0;
    while (n_store < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (n_store < target) begin
      n_fail++;
      $display("FAIL %s: %0d stores after %0d cycles, wanted %0d", name, n_store, k, target);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      model_temp[c]  = 0;
      model_valid[c] = 0;
      model_ot[c]    = 0;
      model_fault[c] = 0;
    end
  endtask

  // ADC responder: answers each request after a random delay
  initial begin
    int lat, d;
    conv_exp_t ce;
    adc_ack  = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_req && !adc_mute && !reset) begin
        check("adc_ch", 64'(adc_ch), 64'(exp_ch));
        if (sample_n == 0) begin
          if (last_start >= 0) check("slot_spacing", 64'(cyc - last_start >= SCAN_DIV), 64'(1));
          last_start = cyc;
        end
        lat = $urandom_range(0, 4);
        repeat (lat) @(negedge clk);
        d = (forced_adc.size() > 0) ? forced_adc.pop_front() : int'($urandom_range(0, 4095));
        adc_ack  = 1'b1;
        adc_data = 12'(d);
        sample_sum += d;
        sample_n++;
        if (sample_n == NSAMP) begin
          ce.ch   = exp_ch;
          ce.code = sample_sum / NSAMP;
          conv_q.push_back(ce);
          sample_sum = 0;
          sample_n   = 0;
        end
        @(negedge clk);
        adc_ack  = 1'b0;
        adc_data = 12'($urandom);
      end
    end
  end

  // Converter responder and conv_code monitor
  initial begin
    int lat, t;
    conv_exp_t  ce;
    store_exp_t se;
    conv_done = 1'b0;
    conv_temp = '0;
    forever begin
      @(negedge clk);
      if (conv_start && !reset) begin
        ce.ch = exp_ch;
        if (conv_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL conv_unexpected: conv_start with code %0d, expected none", conv_code);
        end else begin
          ce = conv_q.pop_front();
          check("conv_code", 64'(conv_code), 64'(ce.code));
        end
        if (conv_hold) begin
          conv_seen = 1;
        end else begin
          lat = $urandom_range(0, 4);
          repeat (lat) @(negedge clk);
          t = (forced_temp.size() > 0) ? forced_temp.pop_front() : int'($urandom_range(0, 700)) - 200;
          conv_done = 1'b1;
          conv_temp = 12'(t);
          se.ch   = ce.ch;
          se.temp = t;
          se.flt  = 0;
          store_q.push_back(se);
          @(negedge clk);
          conv_done = 1'b0;
          conv_temp = 12'($urandom);
        end
      end else if (send_stray) begin
        conv_done = 1'b1;
        conv_temp = 12'd500;
        @(negedge clk);
        conv_done  = 1'b0;
        send_stray = 0;
      end
    end
  end

  // conv_start must be a single-cycle pulse
  always @(negedge clk) begin
    if (conv_start) check("conv_start_pulse", 64'(prev_cs), 64'(0));
    prev_cs = conv_start;
  end

  // Store monitor: a slot ends when busy falls
  always @(negedge clk) begin
    store_exp_t s;
    logic [23:0] ev;
    logic [1:0]  vv, ov, fv;
    if (prev_busy && !busy && !rst_flag) begin
      n_store++;
      if (store_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL store_unexpected: slot ended with temp_out 0x%0h, expected none", temp_out);
      end else begin
        s = store_q.pop_front();
        model_temp[s.ch] = s.temp;
        if (s.flt) begin
          model_valid[s.ch] = 0;
          model_ot[s.ch]    = 1;
          model_fault[s.ch] = 1;
        end else begin
          model_valid[s.ch] = 1;
          model_ot[s.ch]    = (s.temp >= TEMP_MAX);
        end
        for (int c = 0; c < N_CH; c++) begin
          ev[c*12 +: 12] = 12'(model_temp[c]);
          vv[c] = model_valid[c];
          ov[c] = model_ot[c];
          fv[c] = model_fault[c];
        end
        check("temp_out", 64'(temp_out), 64'(ev));
        check("temp_valid", 64'(temp_valid), 64'(vv));
        check("overtemp", 64'(overtemp), 64'(ov));
`ifdef TEMP_SCAN_TIMEOUT_EN
        check("fault", 64'(fault), 64'(fv));
`endif
        exp_ch = (s.ch + 1) % N_CH;
      end
    end
    prev_busy = busy;
  end

  // Main sequence
  initial begin
    int k, reqs;
    reset   = 1'b1;
    scan_en = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_adc_req", 64'(adc_req), 64'(0));
    check("rst_adc_ch", 64'(adc_ch), 64'(0));
    check("rst_conv_start", 64'(conv_start), 64'(0));
    check("rst_conv_code", 64'(conv_code), 64'(0));
    check("rst_temp_out", 64'(temp_out), 64'(0));
    check("rst_temp_valid", 64'(temp_valid), 64'(0));
    check("rst_overtemp", 64'(overtemp), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;

    // Directed: averaging, wrap, threshold edge
    forced_adc  = '{1000, 1002, 1004, 1006, 2048, 2048, 2048, 2048};
    forced_temp = '{25, 60, 280, 100, 279};
    scan_en = 1'b1;
    wait_stores(1, 150, "first_store");
    check("ch0_temp25", 64'(temp_out[11:0]), 64'(25));
    check("valid_01", 64'(temp_valid), 64'(2'b01));
    check("code_1003", 64'(conv_code), 64'(1003));
    wait_stores(2, 150, "second_store");
    check("ch1_temp60", 64'(temp_out[23:12]), 64'(60));
    check("code_2048", 64'(conv_code), 64'(2048));
    check("valid_11", 64'(temp_valid), 64'(2'b11));
    wait_stores(3, 150, "third_store");
    check("ot0_at_280", 64'(overtemp[0]), 64'(1));
    wait_stores(5, 300, "fifth_store");
    check("ot0_at_279", 64'(overtemp[0]), 64'(0));

    // Randomized scan
    wait_stores(n_store + 20, 20 * 100, "random_scan");

    // scan_en dropped during a ch1 sample: slot completes, then idle
    k = 0;
    while (!(adc_req && adc_ch == 1'b1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("found_ch1_req", 64'(adc_req && adc_ch == 1'b1), 64'(1));
    scan_en = 1'b0;
    wait_stores(n_store + 1, 150, "drain_slot");
    reqs = 0;
    repeat (100) begin
      @(negedge clk);
      if (adc_req) reqs++;
    end
    check("no_req_when_off", 64'(reqs), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // Reset during CONV_WAIT
    conv_hold = 1;
    conv_seen = 0;
    scan_en   = 1'b1;
    k = 0;
    while (!conv_seen && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("reached_conv_wait", 64'(conv_seen), 64'(1));
    rst_flag = 1;
    reset    = 1'b1;
    @(negedge clk);
    check("mid_rst_conv_start", 64'(conv_start), 64'(0));
    check("mid_rst_temp_valid", 64'(temp_valid), 64'(0));
    check("mid_rst_temp_out", 64'(temp_out), 64'(0));
    check("mid_rst_overtemp", 64'(overtemp), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    reset   = 1'b0;
    scan_en = 1'b0;
    conv_q.delete();
    store_q.delete();
    model_clear();
    exp_ch     = 0;
    sample_sum = 0;
    sample_n   = 0;
    conv_hold  = 0;
    send_stray = 1;
    k = 0;
    while (send_stray && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("stray_done_valid", 64'(temp_valid), 64'(0));
    check("stray_done_temp", 64'(temp_out), 64'(0));
    check("stray_done_busy", 64'(busy), 64'(0));
    rst_flag = 0;

    // Resume scanning from channel 0 after reset
    scan_en = 1'b1;
    wait_stores(n_store + 10, 10 * 100, "post_reset_scan");

`ifdef TEMP_SCAN_TIMEOUT_EN
    begin
      store_exp_t fe;
      scan_en = 1'b0;
      k = 0;
      while (busy && k < 200) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      adc_mute = 1;
      fe.ch   = exp_ch;
      fe.temp = 300;
      fe.flt  = 1;
      store_q.push_back(fe);
      scan_en = 1'b1;
      wait_stores(n_store + 1, 300, "timeout_slot");
      adc_mute = 0;
      wait_stores(n_store + 1, 200, "after_timeout");
    end
`endif

    // Drain and confirm no leftover expectations
    scan_en = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check("conv_q_empty", 64'(conv_q.size()), 64'(0));
    check("store_q_empty", 64'(store_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
